// File: rtl/lcd_ctrl_pkg.sv
// Command encodings and FSM state codes shared by the parametrised LCD controller
// and its window ALU.
package lcd_ctrl_pkg;

  localparam logic [3:0] CMD_WRITE  = 4'h0;
  localparam logic [3:0] CMD_UP     = 4'h1;
  localparam logic [3:0] CMD_DOWN   = 4'h2;
  localparam logic [3:0] CMD_LEFT   = 4'h3;
  localparam logic [3:0] CMD_RIGHT  = 4'h4;
  localparam logic [3:0] CMD_AVG    = 4'h5;
  localparam logic [3:0] CMD_MIRX   = 4'h6;
  localparam logic [3:0] CMD_MIRY   = 4'h7;
  localparam logic [3:0] CMD_ORIGIN = 4'h8;
  localparam logic [3:0] CMD_ENH    = 4'h9;
  localparam logic [3:0] CMD_DEC    = 4'hA;
  localparam logic [3:0] CMD_THR    = 4'hB;
  localparam logic [3:0] CMD_ITHR   = 4'hC;
  localparam logic [3:0] CMD_ROTCW  = 4'hD;
  localparam logic [3:0] CMD_ROTCCW = 4'hE;
  localparam logic [3:0] CMD_NOP    = 4'hF;

  typedef logic [2:0] state_t;

  localparam state_t S_LOAD  = 3'd0;
  localparam state_t S_IDLE  = 3'd1;
  localparam state_t S_EXEC  = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window processor: average, saturating add/sub, thresholds, mirrors.
// Window rotation (cmd D/E) is compiled in only when LCD_ROTATE_EN is defined.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    cmd,
  input  logic [DW-1:0] tl,
  input  logic [DW-1:0] tr,
  input  logic [DW-1:0] bl,
  input  logic [DW-1:0] br,
  output logic [DW-1:0] tl_n,
  output logic [DW-1:0] tr_n,
  output logic [DW-1:0] bl_n,
  output logic [DW-1:0] br_n,
  output logic          we
);

  localparam logic [DW-1:0] PMAX = '1;
  localparam logic [DW-1:0] MID  = DW'(1) << (DW - 1);
  localparam logic [DW-1:0] STEP = DW'(1) << (DW - 2);

  function automatic logic [DW-1:0] px_op(input logic [3:0] op, input logic [DW-1:0] p);
    logic [DW:0] s;
    s = {1'b0, p} + {1'b0, STEP};
    case (op)
      CMD_ENH:  px_op = s[DW] ? PMAX : s[DW-1:0];
      CMD_DEC:  px_op = (p < STEP) ? '0 : p - STEP;
      CMD_THR:  px_op = (p > MID) ? PMAX : '0;
      CMD_ITHR: px_op = (p < MID) ? PMAX : '0;
      default:  px_op = p;
    endcase
  endfunction

  // Sum of four pixels needs two extra bits; dropping them is floor(sum/4).
  logic [DW+1:0] sum;
  assign sum = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    tl_n = tl;
    tr_n = tr;
    bl_n = bl;
    br_n = br;
    we   = 1'b0;
    case (cmd)
      CMD_AVG: begin
        tl_n = sum[DW+1:2];
        tr_n = sum[DW+1:2];
        bl_n = sum[DW+1:2];
        br_n = sum[DW+1:2];
        we   = 1'b1;
      end
      CMD_MIRX: begin
        tl_n = bl;
        tr_n = br;
        bl_n = tl;
        br_n = tr;
        we   = 1'b1;
      end
      CMD_MIRY: begin
        tl_n = tr;
        tr_n = tl;
        bl_n = br;
        br_n = bl;
        we   = 1'b1;
      end
      CMD_ENH, CMD_DEC, CMD_THR, CMD_ITHR: begin
        tl_n = px_op(cmd, tl);
        tr_n = px_op(cmd, tr);
        bl_n = px_op(cmd, bl);
        br_n = px_op(cmd, br);
        we   = 1'b1;
      end
`ifdef LCD_ROTATE_EN
      CMD_ROTCW: begin
        tl_n = bl;
        tr_n = tl;
        bl_n = br;
        br_n = tr;
        we   = 1'b1;
      end
      CMD_ROTCCW: begin
        tl_n = tr;
        tr_n = br;
        bl_n = tl;
        br_n = bl;
        we   = 1'b1;
      end
`else
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Parametrised image display controller: loads IROM into a buffer, runs host window
// commands through lcd_win_alu, then streams the buffer to IRB. Rotation: LCD_ROTATE_EN.
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DW     = 8,
  parameter int INIT_X = IMG_W / 2 - 1,
  parameter int INIT_Y = IMG_H / 2 - 1,
  localparam int N     = IMG_W * IMG_H,
  localparam int AW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          busy,
  output logic          done,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  input  logic [DW-1:0] IROM_Q,
  output logic          IRB_RW,
  output logic [AW-1:0] IRB_A,
  output logic [DW-1:0] IRB_D
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_N        = CW'(N);
  localparam logic [CW-1:0] CNT_LOAD_END = CW'(N + 1);
  localparam logic [XW-1:0] X_MAX        = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_MAX        = YW'(IMG_H - 2);
  localparam logic [XW-1:0] X_INIT       = XW'(INIT_X);
  localparam logic [YW-1:0] Y_INIT       = YW'(INIT_Y);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    cmd_q;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  logic [DW-1:0] buffer [N];

  // Power-of-two dimensions make y*IMG_W+x a plain concatenation.
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
  assign a_tl = {y, x};
  assign a_tr = {y, x + 1'b1};
  assign a_bl = {y + 1'b1, x};
  assign a_br = {y + 1'b1, x + 1'b1};

  logic [AW-1:0] cnt_addr, cap_addr;
  assign cnt_addr = AW'(cnt);
  // IROM data for address a arrives two edges after the edge that drove a.
  assign cap_addr = AW'(cnt - CW'(2));

  logic [DW-1:0] tl_n, tr_n, bl_n, br_n;
  logic          alu_we;

  lcd_win_alu #(.DW(DW)) u_alu (
    .cmd  (cmd_q),
    .tl   (buffer[a_tl]),
    .tr   (buffer[a_tr]),
    .bl   (buffer[a_bl]),
    .br   (buffer[a_br]),
    .tl_n (tl_n),
    .tr_n (tr_n),
    .bl_n (bl_n),
    .br_n (br_n),
    .we   (alu_we)
  );

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_LOAD;
      cnt     <= '0;
      cmd_q   <= CMD_NOP;
      x       <= X_INIT;
      y       <= Y_INIT;
      busy    <= 1'b1;
      done    <= 1'b0;
      IROM_EN <= 1'b1;
      IROM_A  <= '0;
      IRB_RW  <= 1'b1;
      IRB_A   <= '0;
      IRB_D   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (cnt < CNT_N) begin
            IROM_EN <= 1'b0;
            IROM_A  <= cnt_addr;
          end else begin
            IROM_EN <= 1'b1;
          end
          if (cnt == CNT_LOAD_END) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q <= cmd;
            busy  <= 1'b1;
            if (cmd == CMD_WRITE) begin
              state  <= S_WRITE;
              IRB_RW <= 1'b0;
              IRB_A  <= '0;
              IRB_D  <= buffer[0];
              cnt    <= CW'(1);
            end else begin
              state <= S_EXEC;
            end
          end
        end

        S_EXEC: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          case (cmd_q)
            CMD_UP:     if (y != '0)    y <= y - 1'b1;
            CMD_DOWN:   if (y != Y_MAX) y <= y + 1'b1;
            CMD_LEFT:   if (x != '0)    x <= x - 1'b1;
            CMD_RIGHT:  if (x != X_MAX) x <= x + 1'b1;
            CMD_ORIGIN: begin
              x <= X_INIT;
              y <= Y_INIT;
            end
            default: ;
          endcase
        end

        S_WRITE: begin
          if (cnt == CNT_N) begin
            state  <= S_DONE;
            IRB_RW <= 1'b1;
            IRB_D  <= '0;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            IRB_A <= cnt_addr;
            IRB_D <= buffer[cnt_addr];
            cnt   <= cnt + 1'b1;
          end
        end

        S_DONE: ;

        default: begin
          state <= S_LOAD;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the pixel buffer has no reset; LOAD overwrites every location before it is read.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && cnt >= CW'(2)) begin
      buffer[cap_addr] <= IROM_Q;
    end else if (state == S_EXEC && alu_we) begin
      buffer[a_tl] <= tl_n;
      buffer[a_tr] <= tr_n;
      buffer[a_bl] <= bl_n;
      buffer[a_br] <= br_n;
    end
  end

endmodule
